// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer:
// opcode values, ALU operation codes, mux select encodings, the
// sequencer state enum and the packed control word that the decoder
// produces for the top level.
package mc_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    // ALU operation select
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT       = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_MEMWB  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_RWB    = 4'd8,
        ST_BRANCH = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11,
        ST_JUMP   = 4'd12,
        ST_TRAP   = 4'd13
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memtoreg;
        logic       reg_dst;
        logic       regwrite;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
        logic       err;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Control word decoder for the multi-cycle sequencer.
// Purely combinational: maps the current state (plus mem_ready for the
// FETCH-stage IR/PC load) onto every datapath control line.
// Ports:
//   state_i      current sequencer state
//   mem_ready_i  memory access completes this cycle
//   ctrl_o       full control word (strobes, mux selects, halted, err)
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        // NOTE: every field gets a default before the case so that states
        // that do not mention a field cannot leave it holding a latch.
        ctrl_o = '0;
        ctrl_o.halted = (state_i == ST_IDLE);
        ctrl_o.err    = (state_i == ST_TRAP);

        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC+4 are only captured once the fetch data is valid
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                // Speculative branch target PC + (sext << 2) into ALUOut
                ctrl_o.alu_src_b = SRCB_SEXT_SH2;
                ctrl_o.alu_op    = ALU_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
                ctrl_o.alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            ST_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            ST_MEMWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memtoreg = 1'b1;
            end
            ST_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            ST_RWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.reg_dst  = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.branch    = 1'b1;
                ctrl_o.pc_source = PCSRC_ALUOUT;
            end
            ST_ADDIWB: begin
                ctrl_o.regwrite = 1'b1;
            end
            ST_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: ;  // IDLE and TRAP drive no strobes
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer.
// Holds the state register, next-state logic and the retired-instruction
// counter; control lines come from mc_ctrl_decode.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   op                IR[31:26], valid from DECODE onward
//   zero              ALU zero flag (gated with Branch in the datapath)
//   mem_ready         memory access completes this cycle
//   halt              stop at the next instruction boundary
//   PCWrite..PCSource datapath control lines
//   halted / err      sequencer in IDLE / TRAP
//   instr_count       retired instructions, wraps mod 2^CNT_W
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter bit          TRAP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             halt,
    output logic             PCWrite,
    output logic             Branch,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             Memtoreg,
    output logic             RegDst,
    output logic             Regwrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUop,
    output logic [1:0]       PCSource,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done;
    ctrl_t            ctrl;

    // The zero flag is consumed by the datapath together with Branch.
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        state_d = state_q;
        done    = 1'b0;

        case (state_q)
            ST_IDLE:   state_d = halt ? ST_IDLE : ST_FETCH;
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_R:         state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        // Without trapping, an unknown opcode retires as a NOP
                        if (TRAP_EN) state_d = ST_TRAP;
                        else         done    = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: state_d = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWR:  done = mem_ready;
            ST_EXEC:   state_d = ST_RWB;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_MEMWB, ST_RWB, ST_BRANCH, ST_ADDIWB, ST_JUMP: done = 1'b1;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase

        // Instruction boundary: halt is only honoured here
        if (done) state_d = halt ? ST_IDLE : ST_FETCH;

        cnt_d = done ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // NOTE: state and counter use non-blocking assignments so every
    // register samples the pre-edge values regardless of block ordering.
    // NOTE: reset forces IDLE immediately, which zeroes every strobe
    // combinationally, so no partial write can follow reset assertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign Branch      = ctrl.branch;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign Memtoreg    = ctrl.memtoreg;
    assign RegDst      = ctrl.reg_dst;
    assign Regwrite    = ctrl.regwrite;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUop       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign halted      = ctrl.halted;
    assign err         = ctrl.err;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed scoreboard bench for mc_ctrl_fsm. Expected control words come
// from a bench-side table of what each sequencer state must drive.
module tb_mc_ctrl_fsm;

    typedef enum int {
        T_IDLE, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWR, T_MEMWB,
        T_EXEC, T_RWB, T_BRANCH, T_ADDIEX, T_ADDIWB, T_JUMP, T_TRAP
    } tst_e;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memtoreg;
        logic       reg_dst;
        logic       regwrite;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
        logic       err;
    } exp_t;

    typedef struct {
        string       tag;
        exp_t        w;
        logic [31:0] cnt;
    } sb_t;

    logic        clk, rst_n;
    logic [5:0]  op;
    logic        zero, mem_ready, halt;
    logic        PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
    logic        Memtoreg, RegDst, Regwrite, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ALUop;
    logic        halted, err;
    logic [31:0] instr_count;

    // Second instance with trapping disabled, sharing all inputs
    logic        nt_PCWrite, nt_Branch, nt_IorD, nt_MemRead, nt_MemWrite, nt_IRWrite;
    logic        nt_Memtoreg, nt_RegDst, nt_Regwrite, nt_ALUSrcA;
    logic [1:0]  nt_ALUSrcB, nt_PCSource;
    logic [2:0]  nt_ALUop;
    logic        nt_halted, nt_err;
    logic [31:0] nt_instr_count;

    int          checks, failures;
    logic [31:0] model_cnt;
    sb_t         sb_q[$];

    mc_ctrl_fsm #(.CNT_W(32), .TRAP_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .halt(halt), .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .Memtoreg(Memtoreg), .RegDst(RegDst), .Regwrite(Regwrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
        .PCSource(PCSource), .halted(halted), .err(err),
        .instr_count(instr_count)
    );

    mc_ctrl_fsm #(.CNT_W(32), .TRAP_EN(1'b0)) dut_nt (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .halt(halt), .PCWrite(nt_PCWrite), .Branch(nt_Branch), .IorD(nt_IorD),
        .MemRead(nt_MemRead), .MemWrite(nt_MemWrite), .IRWrite(nt_IRWrite),
        .Memtoreg(nt_Memtoreg), .RegDst(nt_RegDst), .Regwrite(nt_Regwrite),
        .ALUSrcA(nt_ALUSrcA), .ALUSrcB(nt_ALUSrcB), .ALUop(nt_ALUop),
        .PCSource(nt_PCSource), .halted(nt_halted), .err(nt_err),
        .instr_count(nt_instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // What each state must drive, straight from the control table
    function automatic exp_t expect_word(input tst_e s, input logic mr);
        exp_t e;
        e = '0;
        case (s)
            T_IDLE:   e.halted = 1'b1;
            T_FETCH:  begin
                e.mem_read = 1'b1; e.alu_src_b = 2'b01;
                e.ir_write = mr;   e.pc_write  = mr;
            end
            T_DECODE: e.alu_src_b = 2'b11;
            T_MEMADR: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            T_MEMRD:  begin e.mem_read = 1'b1; e.iord = 1'b1; end
            T_MEMWR:  begin e.mem_write = 1'b1; e.iord = 1'b1; end
            T_MEMWB:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            T_EXEC:   begin e.alu_src_a = 1'b1; e.alu_op = 3'b010; end
            T_RWB:    begin e.regwrite = 1'b1; e.reg_dst = 1'b1; end
            T_BRANCH: begin
                e.alu_src_a = 1'b1; e.alu_op = 3'b001;
                e.branch = 1'b1;    e.pc_source = 2'b01;
            end
            T_ADDIEX: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            T_ADDIWB: e.regwrite = 1'b1;
            T_JUMP:   begin e.pc_write = 1'b1; e.pc_source = 2'b10; end
            T_TRAP:   e.err = 1'b1;
            default:  e = '0;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push the expectation for the current cycle, then compare once outputs settle
    task automatic sb_check(input string tag, input tst_e s, input logic mr);
        sb_t item, got;
        exp_t obs;
        mem_ready = mr;
        item.tag = tag;
        item.w   = expect_word(s, mr);
        item.cnt = model_cnt;
        sb_q.push_back(item);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            got = sb_q.pop_front();
            obs = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, Memtoreg,
                   RegDst, Regwrite, ALUSrcA, ALUSrcB, ALUop, PCSource, halted, err};
            checks++;
            assert (obs === got.w) else begin
                failures++;
                $error("FAIL %s_ctrl observed=%b expected=%b", got.tag, obs, got.w);
            end
            checks++;
            assert (instr_count === got.cnt) else begin
                failures++;
                $error("FAIL %s_count observed=%0d expected=%0d", got.tag, instr_count, got.cnt);
            end
        end
    endtask

    // One full cycle: check now, then advance to the next falling edge
    task automatic cyc(input string tag, input tst_e s, input logic mr, input logic hl);
        halt = hl;
        sb_check(tag, s, mr);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0; model_cnt = '0;
        rst_n = 1'b0; op = 6'b0; zero = 1'b0; mem_ready = 1'b0; halt = 1'b0;
        repeat (2) @(negedge clk);
        sb_check("reset", T_IDLE, 1'b1);
        rst_n = 1'b1;

        // lw: 5 cycles after IDLE
        op = 6'b100011;
        cyc("lw_idle",   T_IDLE,   1'b1, 1'b0);
        cyc("lw_fetch",  T_FETCH,  1'b1, 1'b0);
        cyc("lw_decode", T_DECODE, 1'b1, 1'b0);
        cyc("lw_memadr", T_MEMADR, 1'b1, 1'b0);
        cyc("lw_memrd",  T_MEMRD,  1'b1, 1'b0);
        cyc("lw_memwb",  T_MEMWB,  1'b1, 1'b0);
        model_cnt++;

        // beq with zero=1: 3 cycles
        op = 6'b000100; zero = 1'b1;
        cyc("beq_fetch",  T_FETCH,  1'b1, 1'b0);
        cyc("beq_decode", T_DECODE, 1'b1, 1'b0);
        cyc("beq_branch", T_BRANCH, 1'b1, 1'b0);
        model_cnt++;
        zero = 1'b0;

        // R-type with 3 wait cycles in FETCH; IRWrite only on the last
        op = 6'b000000;
        for (int i = 0; i < 3; i++) cyc("r_fetch_wait", T_FETCH, 1'b0, 1'b0);
        cyc("r_fetch",  T_FETCH,  1'b1, 1'b0);
        cyc("r_decode", T_DECODE, 1'b1, 1'b0);
        cyc("r_exec",   T_EXEC,   1'b1, 1'b0);
        cyc("r_rwb",    T_RWB,    1'b1, 1'b0);
        model_cnt++;

        // sw with 2 wait cycles in MEMWR
        op = 6'b101011;
        cyc("sw_fetch",  T_FETCH,  1'b1, 1'b0);
        cyc("sw_decode", T_DECODE, 1'b1, 1'b0);
        cyc("sw_memadr", T_MEMADR, 1'b1, 1'b0);
        cyc("sw_memwr_wait", T_MEMWR, 1'b0, 1'b0);
        cyc("sw_memwr_wait", T_MEMWR, 1'b0, 1'b0);
        cyc("sw_memwr",  T_MEMWR,  1'b1, 1'b0);
        model_cnt++;

        // addi: 4 cycles
        op = 6'b001000;
        cyc("addi_fetch",  T_FETCH,  1'b1, 1'b0);
        cyc("addi_decode", T_DECODE, 1'b1, 1'b0);
        cyc("addi_ex",     T_ADDIEX, 1'b1, 1'b0);
        cyc("addi_wb",     T_ADDIWB, 1'b1, 1'b0);
        model_cnt++;

        // j: 3 cycles
        op = 6'b000010;
        cyc("j_fetch",  T_FETCH,  1'b1, 1'b0);
        cyc("j_decode", T_DECODE, 1'b1, 1'b0);
        cyc("j_jump",   T_JUMP,   1'b1, 1'b0);
        model_cnt++;

        // halt raised mid R-type: instruction still retires, then IDLE
        op = 6'b000000;
        cyc("rh_fetch",  T_FETCH,  1'b1, 1'b0);
        cyc("rh_decode", T_DECODE, 1'b1, 1'b0);
        cyc("rh_exec",   T_EXEC,   1'b1, 1'b1);
        cyc("rh_rwb",    T_RWB,    1'b1, 1'b1);
        model_cnt++;
        cyc("halt_idle", T_IDLE, 1'b1, 1'b1);
        cyc("halt_idle", T_IDLE, 1'b1, 1'b1);
        cyc("resume_idle", T_IDLE, 1'b1, 1'b0);

        // Illegal opcode: trapping instance sticks in TRAP, other retires a NOP
        op = 6'b111111;
        cyc("ill_fetch",  T_FETCH,  1'b1, 1'b0);
        cyc("ill_decode", T_DECODE, 1'b1, 1'b0);
        chk("nt_count",   nt_instr_count, model_cnt + 32'd1);
        chk("nt_err",     {31'b0, nt_err}, 32'd0);
        chk("nt_fetch",   {31'b0, nt_MemRead}, 32'd1);
        for (int i = 0; i < 10; i++) cyc("trap_hold", T_TRAP, 1'b1, 1'b0);

        // Async reset out of TRAP takes effect without a clock edge
        rst_n = 1'b0;
        model_cnt = '0;
        sb_check("trap_reset", T_IDLE, 1'b1);
        chk("nt_reset_count", nt_instr_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a lw read: strobes drop at once
        op = 6'b100011;
        cyc("lw2_idle",   T_IDLE,   1'b1, 1'b0);
        cyc("lw2_fetch",  T_FETCH,  1'b1, 1'b0);
        cyc("lw2_decode", T_DECODE, 1'b1, 1'b0);
        cyc("lw2_memadr", T_MEMADR, 1'b1, 1'b0);
        sb_check("lw2_memrd", T_MEMRD, 1'b1);
        rst_n = 1'b0;
        sb_check("mid_reset", T_IDLE, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequencer runs normally after reset
        op = 6'b000010;
        cyc("j2_idle",   T_IDLE,   1'b1, 1'b0);
        cyc("j2_fetch",  T_FETCH,  1'b1, 1'b0);
        cyc("j2_decode", T_DECODE, 1'b1, 1'b0);
        cyc("j2_jump",   T_JUMP,   1'b1, 1'b0);
        model_cnt++;
        sb_check("j2_next_fetch", T_FETCH, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
